// File: rtl/shared_resource_arbiter_pkg.sv
// Shared types for the two-requester compute resource: requester ids, pipe stage
// record and defaults for the resource parameters.
package shared_resource_pkg;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_LATENCY = 3;
  localparam int DEFAULT_ADD_K   = 1;

  typedef enum logic {
    REQ_1 = 1'b0,
    REQ_2 = 1'b1
  } req_id_t;

  // Stage record at the default width; the top builds the same layout at its own DATA_W.
  typedef struct packed {
    logic                      valid;
    req_id_t                   owner;
    logic [DEFAULT_DATA_W-1:0] data;
  } stage_t;

  function automatic req_id_t other_req(input req_id_t r);
    return (r == REQ_1) ? REQ_2 : REQ_1;
  endfunction

endpackage

// File: rtl/shared_resource_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant from eligible[1:0], with a
// pointer that favours the requester that did not win last.
module rr_arbiter2
  import shared_resource_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  req_id_t ptr_reg;

  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = (ptr_reg == REQ_1) ? 2'b01 : 2'b10;
    end else begin
      grant = eligible;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= REQ_1;
    end else if (grant[0]) begin
      ptr_reg <= other_req(REQ_1);
    end else if (grant[1]) begin
      ptr_reg <= other_req(REQ_2);
    end
  end

endmodule

// File: rtl/shared_resource_arbiter.sv
// Shared compute resource: round-robin admission of two requesters into a LATENCY-deep
// pipe computing data+ADD_K, results routed back to their owner with stall/flush handling.
module shared_resource_arbiter
  import shared_resource_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int ADD_K   = DEFAULT_ADD_K
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_1,
  input  logic              in_flush_1,
  input  logic              in_stall_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_valid_2,
  input  logic              in_flush_2,
  input  logic              in_stall_2,
  output logic [DATA_W-1:0] out_data_1,
  output logic              out_valid_1,
  output logic              out_flush_1,
  output logic              out_stall_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic              out_valid_2,
  output logic              out_flush_2,
  output logic              out_stall_2
);

  typedef struct packed {
    logic              valid;
    req_id_t           owner;
    logic [DATA_W-1:0] data;
  } pipe_stage_t;

  pipe_stage_t stage_reg [LATENCY];
  pipe_stage_t cleaned   [LATENCY];
  pipe_stage_t shift_src [LATENCY];
  pipe_stage_t head;
  pipe_stage_t entry;

  logic [1:0] req_valid;
  logic [1:0] req_flush;
  logic [1:0] req_stall;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic [1:0] out_flush_reg;
  logic       freeze;
  logic       head_is_1;
  logic       head_is_2;

  assign req_valid = {in_valid_2, in_valid_1};
  assign req_flush = {in_flush_2, in_flush_1};
  assign req_stall = {in_stall_2, in_stall_1};

  assign head = stage_reg[LATENCY-1];

  // A stalled head blocks the whole pipe, unless its owner is flushing it away.
  assign freeze = head.valid & req_stall[head.owner] & ~req_flush[head.owner];

  assign eligible = req_valid & ~req_flush & {2{~freeze}};

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .grant    (grant)
  );

  always_comb begin
    entry       = '0;
    entry.valid = |grant;
    entry.owner = grant[1] ? REQ_2 : REQ_1;
    entry.data  = (grant[1] ? in_data_2 : in_data_1) + DATA_W'(ADD_K);
  end

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      // Flushed owner's entries become bubbles in place; neighbours keep their slots.
      assign cleaned[gi] = {stage_reg[gi].valid & ~req_flush[stage_reg[gi].owner],
                            stage_reg[gi].owner, stage_reg[gi].data};

      if (gi == 0) begin : g_first
        assign shift_src[gi] = entry;
      end else begin : g_rest
        assign shift_src[gi] = cleaned[gi-1];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stage_reg[gi] <= '0;
        end else if (freeze) begin
          stage_reg[gi] <= cleaned[gi];
        end else begin
          stage_reg[gi] <= shift_src[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_flush_reg <= 2'b00;
    end else begin
      out_flush_reg <= req_flush;
    end
  end

  assign head_is_1 = reset & head.valid & (head.owner == REQ_1);
  assign head_is_2 = reset & head.valid & (head.owner == REQ_2);

  assign out_valid_1 = head_is_1;
  assign out_valid_2 = head_is_2;
  assign out_data_1  = head_is_1 ? head.data : '0;
  assign out_data_2  = head_is_2 ? head.data : '0;
  assign out_flush_1 = reset & out_flush_reg[0];
  assign out_flush_2 = reset & out_flush_reg[1];
  assign out_stall_1 = reset & in_valid_1 & ~in_flush_1 & ~grant[0];
  assign out_stall_2 = reset & in_valid_2 & ~in_flush_2 & ~grant[1];

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Randomised bench for shared_resource_arbiter: a reference model of in-flight requests
// predicts handshakes each cycle, and a scoreboard checks every delivered result.
module tb_shared_resource_arbiter;

  localparam int DATA_W  = 32;
  localparam int LATENCY = 3;
  localparam int ADD_K   = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] in_data_1 = '0, in_data_2 = '0;
  logic              in_valid_1 = 0, in_flush_1 = 0, in_stall_1 = 0;
  logic              in_valid_2 = 0, in_flush_2 = 0, in_stall_2 = 0;
  logic [DATA_W-1:0] out_data_1, out_data_2;
  logic              out_valid_1, out_flush_1, out_stall_1;
  logic              out_valid_2, out_flush_2, out_stall_2;

  shared_resource_arbiter #(.DATA_W(DATA_W), .LATENCY(LATENCY), .ADD_K(ADD_K)) dut (
    .clk(clk), .reset(reset),
    .in_data_1(in_data_1), .in_valid_1(in_valid_1), .in_flush_1(in_flush_1), .in_stall_1(in_stall_1),
    .in_data_2(in_data_2), .in_valid_2(in_valid_2), .in_flush_2(in_flush_2), .in_stall_2(in_stall_2),
    .out_data_1(out_data_1), .out_valid_1(out_valid_1), .out_flush_1(out_flush_1), .out_stall_1(out_stall_1),
    .out_data_2(out_data_2), .out_valid_2(out_valid_2), .out_flush_2(out_flush_2), .out_stall_2(out_stall_2)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted request with its age in non-frozen cycles.
  typedef struct {
    int          owner;
    logic [31:0] data;
    int          age;
  } req_rec_t;

  req_rec_t    model_q[$];
  int          model_ptr = 0;
  logic [1:0]  model_flush_prev = 2'b00;
  logic [31:0] sb_q1[$];
  logic [31:0] sb_q2[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_ptr = 0;
    model_flush_prev = 2'b00;
    sb_q1.delete();
    sb_q2.delete();
  endtask

  // Predict this cycle's outputs from current inputs, compare, then advance the model.
  task automatic model_step();
    logic [1:0]  v, f, s, ev;
    logic [31:0] d[2];
    logic [31:0] ed[2];
    int          h, win;
    logic        freeze;
    v = {in_valid_2, in_valid_1};
    f = {in_flush_2, in_flush_1};
    s = {in_stall_2, in_stall_1};
    d[0] = in_data_1;
    d[1] = in_data_2;
    ev = 2'b00;
    ed[0] = '0;
    ed[1] = '0;
    h = -1;
    for (int i = 0; i < model_q.size(); i++)
      if (model_q[i].age == LATENCY) h = i;
    if (h >= 0) begin
      ev[model_q[h].owner] = 1'b1;
      ed[model_q[h].owner] = model_q[h].data;
    end
    freeze = (h >= 0) && s[model_q[h].owner] && !f[model_q[h].owner];
    win = -1;
    if (!freeze) begin
      if (v[0] && !f[0] && v[1] && !f[1]) win = model_ptr;
      else if (v[0] && !f[0]) win = 0;
      else if (v[1] && !f[1]) win = 1;
    end

    chk("out_valid_1", out_valid_1, ev[0]);
    chk("out_valid_2", out_valid_2, ev[1]);
    chk("out_data_1", out_data_1, ed[0]);
    chk("out_data_2", out_data_2, ed[1]);
    chk("out_stall_1", out_stall_1, v[0] && !f[0] && win != 0);
    chk("out_stall_2", out_stall_2, v[1] && !f[1] && win != 1);
    chk("out_flush_1", out_flush_1, model_flush_prev[0]);
    chk("out_flush_2", out_flush_2, model_flush_prev[1]);

    for (int i = model_q.size() - 1; i >= 0; i--)
      if (f[model_q[i].owner]) model_q.delete(i);
    if (!freeze) begin
      for (int i = model_q.size() - 1; i >= 0; i--)
        if (model_q[i].age == LATENCY) model_q.delete(i);
      foreach (model_q[i]) model_q[i].age++;
    end
    if (win >= 0) begin
      req_rec_t r;
      r.owner = win;
      r.data  = d[win] + 32'(ADD_K);
      r.age   = 1;
      model_q.push_back(r);
      if (win == 0) sb_q1.push_back(r.data);
      else          sb_q2.push_back(r.data);
      model_ptr = 1 - win;
    end
    model_flush_prev = f;
  endtask

  task automatic drive(input logic v1, input logic [31:0] d1, input logic f1, input logic s1,
                       input logic v2, input logic [31:0] d2, input logic f2, input logic s2);
    @(posedge clk);
    #1;
    in_valid_1 = v1; in_data_1 = d1; in_flush_1 = f1; in_stall_1 = s1;
    in_valid_2 = v2; in_data_2 = d2; in_flush_2 = f2; in_stall_2 = s2;
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data_1"}, out_data_1, 0);
    chk({tag, "_data_2"}, out_data_2, 0);
    chk({tag, "_flags"}, {out_valid_1, out_flush_1, out_stall_1, out_valid_2, out_flush_2, out_stall_2}, 0);
  endtask

  task automatic sb_step(input int idx, input logic ov, input logic [31:0] od,
                         input logic st, input logic fl);
    logic [31:0] e;
    if (ov && !st && !fl) begin
      if ((idx == 0 && sb_q1.size() == 0) || (idx == 1 && sb_q2.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_%0d actual=%08h required=no result", idx + 1, od);
      end else begin
        e = (idx == 0) ? sb_q1.pop_front() : sb_q2.pop_front();
        chk(idx == 0 ? "sb_data_1" : "sb_data_2", od, e);
        $display("result p%0d data=%08h expected=%08h", idx + 1, od, e);
      end
    end
    if (fl) begin
      if (idx == 0) sb_q1.delete();
      else          sb_q2.delete();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_step(0, out_valid_1, out_data_1, in_stall_1, in_flush_1);
        sb_step(1, out_valid_2, out_data_2, in_stall_2, in_flush_2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic v1, v2, f1, f2, s1, s2;
    logic [31:0] d1, d2;
    model_reset();
    #2;
    check_all_zero("reset_hold");
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_all_zero("reset_release");

    // single request, 3-cycle latency
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
    idle(5);
    // both requesting: alternating grants
    for (int i = 0; i < 6; i++) drive(1, 32'h100, 0, 0, 1, 32'h200, 0, 0);
    idle(4);
    // head stall for 4 cycles with both requesting
    drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 4; i++) drive(1, 32'h20, 0, 1, 1, 32'h30, 0, 0);
    idle(5);
    // flush pipeline 1 with both owners in flight
    for (int i = 0; i < 3; i++) drive(1, 32'h300 + i, 0, 0, 1, 32'h400 + i, 0, 0);
    drive(1, 32'h3ff, 1, 0, 0, 0, 0, 0);
    idle(5);
    // wrap-around
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    idle(4);
    // mid-cycle reset with entries in flight
    drive(1, 32'h500, 0, 0, 1, 32'h600, 0, 0);
    drive(1, 32'h501, 0, 0, 1, 32'h601, 0, 0);
    @(posedge clk);
    #1 in_valid_1 = 1; in_valid_2 = 1;
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    in_valid_1 = 0; in_valid_2 = 0; in_data_1 = 0; in_data_2 = 0;
    @(posedge clk);
    #3 reset = 1'b1;
    idle(4);
    drive(1, 32'h700, 0, 0, 1, 32'h800, 0, 0);
    idle(5);

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      v1 = ($urandom_range(0, 9) < 7);
      v2 = ($urandom_range(0, 9) < 7);
      f1 = ($urandom_range(0, 24) == 0);
      f2 = ($urandom_range(0, 24) == 0);
      s1 = ($urandom_range(0, 3) == 0);
      s2 = ($urandom_range(0, 3) == 0);
      d1 = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      d2 = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      drive(v1, d1, f1, s1, v2, d2, f2, s2);
    end
    idle(LATENCY + 3);
    chk("sb_drained_1", sb_q1.size(), 0);
    chk("sb_drained_2", sb_q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
